// File: rtl/uart_tx_8n1_if.sv
// Handshake and line signals of the 8N1 UART transmitter.
// The host side drives the byte and the request; the transmitter drives
// the serial line and the status flags.
interface uart_tx_8n1_if;
  logic [7:0] dataIN;
  logic       startIN;
  logic       txOUT;
  logic       busyOUT;
  logic       doneOUT;

  modport master (
    output dataIN,
    output startIN,
    input  txOUT,
    input  busyOUT,
    input  doneOUT
  );

  modport slave (
    input  dataIN,
    input  startIN,
    output txOUT,
    output busyOUT,
    output doneOUT
  );
endinterface

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop
// bit. Each bit lasts DIV = clkFreq/baudRate clock cycles. The line, busy
// and done flags are all registered, so txOUT never glitches.
module uart_tx_8n1 #(
  parameter int clkFreq  = 50_000_000,
  parameter int baudRate = 9600
) (
  input logic          clkIN,
  input logic          nResetIN,
  uart_tx_8n1_if.slave bus
);

  localparam int DIV = clkFreq / baudRate;
  localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_tx_8n1: clkFreq/baudRate must be at least 2");
    end
  endgenerate

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          tx;
  logic          busy;
  logic          done;
  logic          baud_end;

  assign baud_end    = (baud_cnt == BAUD_LAST);
  assign bus.txOUT   = tx;
  assign bus.busyOUT = busy;
  assign bus.doneOUT = done;

  // Frame sequencer: counts DIV cycles per bit and loads the next line
  // level one edge ahead so the registered output changes on bit boundaries.
  always_ff @(posedge clkIN) begin
    if (!nResetIN) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.startIN) begin
            shift    <= bus.dataIN;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            shift    <= {1'b0, shift[7:1]};
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1 at DIV=10: a frame-level model (remaining-cycle
// count plus a 10-bit frame image) predicts txOUT/busyOUT/doneOUT every
// cycle, a mid-bit sampler decodes every frame, and directed scenarios
// pin the model with hand-computed literals.
module tb_uart_tx_8n1;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * DIV;
  localparam int NRAND    = 300;

  logic clkIN    = 1'b0;
  logic nResetIN = 1'b0;

  uart_tx_8n1_if bus ();

  uart_tx_8n1 #(.clkFreq(CLK_FREQ), .baudRate(BAUD)) dut (
    .clkIN   (clkIN),
    .nResetIN(nResetIN),
    .bus     (bus)
  );

  always #5 clkIN = ~clkIN;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame model: m_rem = busy cycles still to go; the frame image is
  // {stop, data, start} and bit k covers DIV consecutive busy cycles.
  int         m_rem         = 0;
  int         m_frames_done = 0;
  logic [9:0] m_frame       = '1;
  logic [7:0] m_byte        = '0;
  logic       m_done        = 1'b0;
  logic       m_rst         = 1'b0;
  logic       m_armed       = 1'b0;

  always @(posedge clkIN) begin
    m_armed <= 1'b1;
    m_rst   <= !nResetIN;
    if (!nResetIN) begin
      m_rem  <= 0;
      m_done <= 1'b0;
    end else if (m_rem == 0) begin
      m_done <= 1'b0;
      if (bus.startIN) begin
        m_byte  <= bus.dataIN;
        m_frame <= {1'b1, bus.dataIN, 1'b0};
        m_rem   <= FRAME;
      end
    end else begin
      m_rem  <= m_rem - 1;
      m_done <= (m_rem == 1);
      if (m_rem == 1) m_frames_done <= m_frames_done + 1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clkIN) begin
    if (m_armed) begin
      check("tx_model",   32'(bus.txOUT),
            32'((m_rem == 0) ? 1'b1 : m_frame[(FRAME - m_rem) / DIV]));
      check("busy_model", 32'(bus.busyOUT), 32'(m_rem != 0));
      check("done_model", 32'(bus.doneOUT), 32'(m_done));
    end
  end

  // Mid-bit sampler: starts on the first low line cycle, samples each bit
  // DIV/2 cycles into it and checks framing and payload.
  logic       d_active = 1'b0;
  int         d_cnt    = 0;
  int         d_frames = 0;
  logic [8:0] d_bits   = '0;
  logic [7:0] d_last   = '0;

  always @(negedge clkIN) begin
    if (m_rst) begin
      d_active <= 1'b0;
    end else if (!d_active) begin
      if (m_armed && bus.txOUT === 1'b0) begin
        d_active <= 1'b1;
        d_cnt    <= 1;
      end
    end else begin
      if (d_cnt == 9 * DIV + DIV / 2) begin
        check("start_bit", 32'(d_bits[0]), 32'(1'b0));
        check("stop_bit",  32'(bus.txOUT), 32'(1'b1));
        check("rx_byte",   32'(d_bits[8:1]), 32'(m_byte));
        d_last   <= d_bits[8:1];
        d_frames <= d_frames + 1;
        d_active <= 1'b0;
      end else if (d_cnt % DIV == DIV / 2) begin
        d_bits[d_cnt / DIV] <= bus.txOUT;
      end
      d_cnt <= d_cnt + 1;
    end
  end

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clkIN);
    bus.dataIN  = d;
    bus.startIN = 1'b1;
    @(negedge clkIN);
    bus.startIN = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clkIN);
      n++;
    end while (bus.doneOUT !== 1'b1 && n < budget);
    check(name, 32'(bus.doneOUT), 32'(1'b1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp_55;
    logic [9:0] got_55;
    int busy_cnt, done_cnt, done_at, high, rises;
    logic gap_done, prev_busy;

    bus.dataIN  = 8'h55;
    bus.startIN = 1'b1;

    // Reset with a pending request: request must be ignored.
    repeat (3) @(negedge clkIN);
    check("rst_tx",   32'(bus.txOUT),   32'(1'b1));
    check("rst_busy", 32'(bus.busyOUT), 32'(1'b0));
    check("rst_done", 32'(bus.doneOUT), 32'(1'b0));

    // Release reset with startIN still high: accepted on the first edge.
    exp_55   = 10'b1010101010;
    got_55   = '0;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = 0;
    nResetIN = 1'b1;
    for (int c = 1; c <= 101; c++) begin
      @(negedge clkIN);
      if (c == 1) bus.startIN = 1'b0;
      if (bus.busyOUT === 1'b1) busy_cnt++;
      if (bus.doneOUT === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (c <= FRAME && (c - 1) % DIV == DIV / 2) got_55[(c - 1) / DIV] = bus.txOUT;
    end
    for (int k = 0; k < 10; k++) check("bits_55", 32'(got_55[k]), 32'(exp_55[k]));
    check("busy_len_55", 32'(busy_cnt), 32'd100);
    check("done_cnt_55", 32'(done_cnt), 32'd1);
    check("done_at_55",  32'(done_at),  32'd101);

    // Payload change mid-frame must not alter the frame.
    pulse_start(8'hA3);
    repeat (29) @(negedge clkIN);
    bus.dataIN = 8'h00;
    wait_done("a3_done", 150);
    check("a3_byte", 32'(d_last), 32'h000000A3);

    // startIN held: two frames, 11 high cycles from stop-bit start to next start.
    @(negedge clkIN);
    bus.dataIN  = 8'hFF;
    bus.startIN = 1'b1;
    done_cnt = 0;
    high     = 0;
    gap_done = 1'b0;
    for (int c = 1; c <= 215; c++) begin
      @(negedge clkIN);
      if (c == 1)   bus.dataIN  = 8'h00;
      if (c == 102) bus.startIN = 1'b0;
      if (bus.doneOUT === 1'b1) done_cnt++;
      if (c > 9 * DIV && !gap_done) begin
        if (bus.txOUT === 1'b1) high++;
        else gap_done = 1'b1;
      end
    end
    check("b2b_done_cnt", 32'(done_cnt), 32'd2);
    check("b2b_gap",      32'(high),     32'(DIV + 1));
    check("b2b_byte2",    32'(d_last),   32'h00000000);

    // Reset at cycle 45 aborts the frame; a new request is taken right after.
    pulse_start(8'h3C);
    repeat (44) @(negedge clkIN);
    nResetIN = 1'b0;
    @(negedge clkIN);
    check("abort_tx",   32'(bus.txOUT),   32'(1'b1));
    check("abort_busy", 32'(bus.busyOUT), 32'(1'b0));
    check("abort_done", 32'(bus.doneOUT), 32'(1'b0));
    nResetIN    = 1'b1;
    bus.dataIN  = 8'h81;
    bus.startIN = 1'b1;
    @(negedge clkIN);
    bus.startIN = 1'b0;
    check("restart_busy", 32'(bus.busyOUT), 32'(1'b1));
    check("restart_tx",   32'(bus.txOUT),   32'(1'b0));
    done_cnt = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clkIN);
      if (bus.doneOUT === 1'b1) done_cnt++;
    end
    check("restart_done_cnt", 32'(done_cnt), 32'd1);
    check("restart_byte",     32'(d_last),   32'h00000081);

    // Request at cycle 50 of a frame is ignored.
    pulse_start(8'h96);
    repeat (48) @(negedge clkIN);
    bus.dataIN  = 8'h11;
    bus.startIN = 1'b1;
    @(negedge clkIN);
    bus.startIN = 1'b0;
    done_cnt  = 0;
    rises     = 0;
    prev_busy = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clkIN);
      if (bus.doneOUT === 1'b1) done_cnt++;
      if (bus.busyOUT === 1'b1 && !prev_busy) rises++;
      prev_busy = bus.busyOUT;
    end
    check("ignore_done_cnt", 32'(done_cnt), 32'd1);
    check("ignore_rises",    32'(rises),    32'd0);
    check("ignore_byte",     32'(d_last),   32'h00000096);

    // Random payloads with random mid-frame input noise.
    for (int i = 0; i < NRAND; i++) begin
      int n;
      pulse_start(8'($urandom));
      n = 0;
      do begin
        @(negedge clkIN);
        n++;
        bus.dataIN  = 8'($urandom);
        bus.startIN = ($urandom_range(0, 15) == 0);
      end while (bus.doneOUT !== 1'b1 && n < 150);
      bus.startIN = 1'b0;
      check("rand_done", 32'(bus.doneOUT), 32'(1'b1));
      repeat ($urandom_range(0, 2)) @(negedge clkIN);
    end
    repeat (3) @(negedge clkIN);

    check("frames_decoded", 32'(d_frames),      32'(m_frames_done));
    check("frames_total",   32'(m_frames_done), 32'(6 + NRAND));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
